insight_hpm_counter_bank: RTL and testbench

- Parametrised bank of hardware performance-monitor counters.
- Successor to the single-counter event_sel/inc hookup: N counters, each with its own event-select mask over a vector of multi-bit event-increment lanes.
- Adds per-counter inhibit, software write, sticky overflow and a pipelined increment stage.
- Sits between the hart's event sources and the CSR file; the CSR file drives configuration, counter writes and reads.

---
 rtl/insight_hpm_counter_bank.sv | 167 ++++++++++++++++
 tb/tb_insight_hpm_counter_bank.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/insight_hpm_counter_bank.sv
// insight_hpm_counter_bank
// -------------------------
// Bank of NUM_CTRS hardware performance-monitor counters. Each counter owns an
// event-select mask over NUM_EVENTS multi-bit increment lanes. The increment is
// summed and registered in stage 1 (inc_q), then added to the counter in stage 2,
// so an event sampled in cycle t shows on rd_data from cycle t+2.
//
// Ports
//   clock      in   sole clock
//   reset      in   synchronous, active-high reset
//   evt_inc    in   per-lane increments, lane k at [k*INC_W +: INC_W]
//   inhibit    in   per-counter count inhibit (forces stage-1 sum to 0)
//   cfg_we     in   write event_sel[cfg_idx] <= cfg_wdata
//   cfg_idx    in   config target (out-of-range index: write ignored)
//   cfg_wdata  in   new event_sel mask
//   ctr_we     in   write counter[ctr_idx] <= ctr_wdata (beats stage 2)
//   ctr_idx    in   counter write target (out-of-range index: write ignored)
//   ctr_wdata  in   new counter value
//   ovf_clr    in   per-counter clear of the sticky overflow flag
//   rd_idx     in   read select
//   rd_data    out  counter[rd_idx], 0 when rd_idx is out of range
//   rd_sel     out  event_sel[rd_idx], 0 when rd_idx is out of range
//   ovf        out  sticky overflow flags
//   snap_req   in   snapshot request          (INSIGHT_HPM_SNAPSHOT_EN only)
//   snap_data  out  snapshot of all counters  (INSIGHT_HPM_SNAPSHOT_EN only)
//
// Interface semantics: there is no valid/ready handshake; every input is sampled
// on every rising clock edge and all counters update in parallel.
//
// Optional feature macro: INSIGHT_HPM_SNAPSHOT_EN adds snap_req/snap_data and
// the snapshot registers. Without it those ports and registers do not exist.

module insight_hpm_counter_bank #(
  parameter int  NUM_CTRS   = 4,
  parameter int  CTR_WIDTH  = 40,
  parameter int  NUM_EVENTS = 32,
  parameter int  INC_W      = 2,
  localparam int SUM_W      = $clog2(NUM_EVENTS * ((1 << INC_W) - 1) + 1),
  localparam int IDX_W      = (NUM_CTRS > 1) ? $clog2(NUM_CTRS) : 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_EVENTS*INC_W-1:0] evt_inc,
  input  logic [NUM_CTRS-1:0]         inhibit,
  input  logic                        cfg_we,
  input  logic [IDX_W-1:0]            cfg_idx,
  input  logic [NUM_EVENTS-1:0]       cfg_wdata,
  input  logic                        ctr_we,
  input  logic [IDX_W-1:0]            ctr_idx,
  input  logic [CTR_WIDTH-1:0]        ctr_wdata,
  input  logic [NUM_CTRS-1:0]         ovf_clr,
  input  logic [IDX_W-1:0]            rd_idx,
  output logic [CTR_WIDTH-1:0]        rd_data,
  output logic [NUM_EVENTS-1:0]       rd_sel,
  output logic [NUM_CTRS-1:0]         ovf
`ifdef INSIGHT_HPM_SNAPSHOT_EN
  ,
  input  logic                        snap_req,
  output logic [NUM_CTRS*CTR_WIDTH-1:0] snap_data
`endif
);

  // The stage-1 sum must fit in a counter with room to spare.
  generate
    if (CTR_WIDTH <= SUM_W) begin : g_width_check
      $error("insight_hpm_counter_bank: CTR_WIDTH must exceed SUM_W");
    end
  endgenerate

  logic [CTR_WIDTH-1:0]  ctr_q   [NUM_CTRS];
  logic [CTR_WIDTH-1:0]  ctr_d   [NUM_CTRS];
  logic [NUM_EVENTS-1:0] sel_q   [NUM_CTRS];
  logic [NUM_EVENTS-1:0] sel_d   [NUM_CTRS];
  logic [SUM_W-1:0]      inc_q   [NUM_CTRS];
  logic [SUM_W-1:0]      inc_d   [NUM_CTRS];
  logic [CTR_WIDTH:0]    add_ext [NUM_CTRS];
  logic [NUM_CTRS-1:0]   ovf_set;
  logic [NUM_CTRS-1:0]   ovf_q;
  logic [NUM_CTRS-1:0]   ovf_d;

  // Stage 1: masked sum of the lane increments, computed at full SUM_W width so
  // it can never truncate. Inhibit zeroes the whole sum.
  always_comb begin
    for (int i = 0; i < NUM_CTRS; i++) begin
      inc_d[i] = '0;
      if (!inhibit[i]) begin
        for (int k = 0; k < NUM_EVENTS; k++) begin
          if (sel_q[i][k]) begin
            inc_d[i] = inc_d[i] + SUM_W'(evt_inc[k*INC_W +: INC_W]);
          end
        end
      end
    end
  end

  // Stage 2 plus configuration. A counter write replaces the stage-2 result
  // outright, so the pending inc_q for that counter is dropped along with any
  // carry it would have produced. Overflow set takes priority over clear.
  always_comb begin
    ovf_set = '0;
    ovf_d   = '0;
    for (int i = 0; i < NUM_CTRS; i++) begin
      sel_d[i]   = (cfg_we && (cfg_idx == IDX_W'(i))) ? cfg_wdata : sel_q[i];
      add_ext[i] = {1'b0, ctr_q[i]} + (CTR_WIDTH+1)'(inc_q[i]);
      if (ctr_we && (ctr_idx == IDX_W'(i))) begin
        ctr_d[i]   = ctr_wdata;
        ovf_set[i] = 1'b0;
      end else begin
        ctr_d[i]   = add_ext[i][CTR_WIDTH-1:0];
        ovf_set[i] = add_ext[i][CTR_WIDTH];
      end
      ovf_d[i] = ovf_set[i] | (ovf_q[i] & ~ovf_clr[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CTRS; i++) begin
        ctr_q[i] <= '0;
        sel_q[i] <= '0;
        inc_q[i] <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CTRS; i++) begin
        ctr_q[i] <= ctr_d[i];
        sel_q[i] <= sel_d[i];
        inc_q[i] <= inc_d[i];
      end
      ovf_q <= ovf_d;
    end
  end

  // Read port: a compare-per-counter mux so indices beyond NUM_CTRS read as 0
  // even when NUM_CTRS is not a power of two.
  always_comb begin
    rd_data = '0;
    rd_sel  = '0;
    for (int i = 0; i < NUM_CTRS; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_data = ctr_q[i];
        rd_sel  = sel_q[i];
      end
    end
  end

  assign ovf = ovf_q;

`ifdef INSIGHT_HPM_SNAPSHOT_EN
  // Snapshot captures the post-update values (ctr_d), i.e. what rd_data will
  // show in the next cycle, including a same-cycle software write.
  logic [NUM_CTRS*CTR_WIDTH-1:0] snap_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      snap_q <= '0;
    end else if (snap_req) begin
      for (int i = 0; i < NUM_CTRS; i++) begin
        snap_q[i*CTR_WIDTH +: CTR_WIDTH] <= ctr_d[i];
      end
    end
  end

  assign snap_data = snap_q;
`endif

endmodule

// File: tb/tb_insight_hpm_counter_bank.sv
// Testbench for insight_hpm_counter_bank. A second, 3-counter instance shares
// the stimulus so that index 3 is out of range for it while still addressing
// counter 3 of the main 4-counter instance.

module tb_insight_hpm_counter_bank;

  logic        clock;
  logic        reset;
  logic [63:0] evt_inc;
  logic [3:0]  inhibit;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [31:0] cfg_wdata;
  logic        ctr_we;
  logic [1:0]  ctr_idx;
  logic [39:0] ctr_wdata;
  logic [3:0]  ovf_clr;
  logic [1:0]  rd_idx;
  logic [39:0] rd_data;
  logic [31:0] rd_sel;
  logic [3:0]  ovf;
  logic [39:0] rd_data3;
  logic [31:0] rd_sel3;
  logic [2:0]  ovf3;
`ifdef INSIGHT_HPM_SNAPSHOT_EN
  logic         snap_req;
  logic [159:0] snap_data;
  logic [119:0] snap_data3;
`endif

  int checks   = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- DUTs ----------------
  insight_hpm_counter_bank u_dut (
    .clock     (clock),
    .reset     (reset),
    .evt_inc   (evt_inc),
    .inhibit   (inhibit),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_wdata (cfg_wdata),
    .ctr_we    (ctr_we),
    .ctr_idx   (ctr_idx),
    .ctr_wdata (ctr_wdata),
    .ovf_clr   (ovf_clr),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data),
    .rd_sel    (rd_sel),
    .ovf       (ovf)
`ifdef INSIGHT_HPM_SNAPSHOT_EN
    ,
    .snap_req  (snap_req),
    .snap_data (snap_data)
`endif
  );

  insight_hpm_counter_bank #(.NUM_CTRS(3)) u_dut3 (
    .clock     (clock),
    .reset     (reset),
    .evt_inc   (evt_inc),
    .inhibit   (inhibit[2:0]),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_wdata (cfg_wdata),
    .ctr_we    (ctr_we),
    .ctr_idx   (ctr_idx),
    .ctr_wdata (ctr_wdata),
    .ovf_clr   (ovf_clr[2:0]),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data3),
    .rd_sel    (rd_sel3),
    .ovf       (ovf3)
`ifdef INSIGHT_HPM_SNAPSHOT_EN
    ,
    .snap_req  (snap_req),
    .snap_data (snap_data3)
`endif
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic [63:0] evt;
    logic [3:0]  inh;
    logic [3:0]  clr;
    logic        cw;
    logic [1:0]  ci;
    logic [31:0] cd;
    logic        ww;
    logic [1:0]  wi;
    logic [39:0] wd;
    logic [1:0]  rd;
    logic [39:0] exp_rd;
    logic [3:0]  exp_ovf;
  } vec_t;

  vec_t        vecs[$];
  logic [39:0] exp_q[$];

  function automatic vec_t mkv(input logic [63:0] evt, input logic [3:0] inh,
                               input logic [3:0] clr, input logic cw,
                               input logic [1:0] ci, input logic [31:0] cd,
                               input logic ww, input logic [1:0] wi,
                               input logic [39:0] wd, input logic [1:0] rd,
                               input logic [39:0] er, input logic [3:0] eo);
    vec_t v;
    v.evt = evt; v.inh = inh; v.clr = clr;
    v.cw = cw; v.ci = ci; v.cd = cd;
    v.ww = ww; v.wi = wi; v.wd = wd;
    v.rd = rd; v.exp_rd = er; v.exp_ovf = eo;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    evt_inc   = '0;
    inhibit   = '0;
    cfg_we    = 1'b0;
    cfg_idx   = '0;
    cfg_wdata = '0;
    ctr_we    = 1'b0;
    ctr_idx   = '0;
    ctr_wdata = '0;
    ovf_clr   = '0;
    rd_idx    = '0;
`ifdef INSIGHT_HPM_SNAPSHOT_EN
    snap_req  = 1'b0;
`endif
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    evt_inc   = v.evt;
    inhibit   = v.inh;
    ovf_clr   = v.clr;
    cfg_we    = v.cw;
    cfg_idx   = v.ci;
    cfg_wdata = v.cd;
    ctr_we    = v.ww;
    ctr_idx   = v.wi;
    ctr_wdata = v.wd;
    rd_idx    = v.rd;
    tick();
    check($sformatf("vec%0d_rd_data", idx), 64'(rd_data), 64'(v.exp_rd));
    check($sformatf("vec%0d_ovf", idx), 64'(ovf), 64'(v.exp_ovf));
  endtask

  // ---------------- test ----------------
  initial begin
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    check("reset_rd_data", 64'(rd_data), 64'h0);
    check("reset_rd_sel", 64'(rd_sel), 64'h0);
    check("reset_ovf", 64'(ovf), 64'h0);
`ifdef INSIGHT_HPM_SNAPSHOT_EN
    check("reset_snap", 64'(snap_data[39:0] | snap_data[79:40]), 64'h0);
`endif
    reset = 1'b0;

    // Counter 0 on lane 0, lane0=3 for 10 cycles: 2-cycle latency, total 30.
    vecs.push_back(mkv(64'h0, 4'h0, 4'h0, 1'b1, 2'd0, 32'h1, 1'b0, 2'd0, 40'h0, 2'd0, 40'd0, 4'h0));
    for (int n = 1; n <= 10; n++)
      vecs.push_back(mkv(64'h3, 4'h0, 4'h0, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 40'h0, 2'd0, 40'(3*(n-1)), 4'h0));
    vecs.push_back(mkv(64'h0, 4'h0, 4'h0, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 40'h0, 2'd0, 40'd30, 4'h0));
    vecs.push_back(mkv(64'h0, 4'h0, 4'h0, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 40'h0, 2'd0, 40'd30, 4'h0));
    for (int r = 1; r <= 3; r++)
      vecs.push_back(mkv(64'h0, 4'h0, 4'h0, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 40'h0, 2'(r), 40'd0, 4'h0));

    // Counter 1 on lanes 1,2 (lane1=2, lane2=1 -> 3/cycle); then with inhibit.
    vecs.push_back(mkv(64'h0, 4'h0, 4'h0, 1'b1, 2'd1, 32'h6, 1'b0, 2'd0, 40'h0, 2'd1, 40'd0, 4'h0));
    for (int n = 1; n <= 5; n++)
      vecs.push_back(mkv(64'h18, 4'h0, 4'h0, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 40'h0, 2'd1, 40'(3*(n-1)), 4'h0));
    vecs.push_back(mkv(64'h0, 4'h0, 4'h0, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 40'h0, 2'd1, 40'd15, 4'h0));
    vecs.push_back(mkv(64'h0, 4'h0, 4'h0, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 40'h0, 2'd1, 40'd15, 4'h0));
    vecs.push_back(mkv(64'h0, 4'h0, 4'h0, 1'b0, 2'd0, 32'h0, 1'b1, 2'd1, 40'h0, 2'd1, 40'd0, 4'h0));
    vecs.push_back(mkv(64'h18, 4'h0, 4'h0, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 40'h0, 2'd1, 40'd0, 4'h0));
    vecs.push_back(mkv(64'h18, 4'h2, 4'h0, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 40'h0, 2'd1, 40'd3, 4'h0));
    vecs.push_back(mkv(64'h18, 4'h2, 4'h0, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 40'h0, 2'd1, 40'd3, 4'h0));
    vecs.push_back(mkv(64'h18, 4'h0, 4'h0, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 40'h0, 2'd1, 40'd3, 4'h0));
    vecs.push_back(mkv(64'h18, 4'h0, 4'h0, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 40'h0, 2'd1, 40'd6, 4'h0));
    vecs.push_back(mkv(64'h0, 4'h0, 4'h0, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 40'h0, 2'd1, 40'd9, 4'h0));
    vecs.push_back(mkv(64'h0, 4'h0, 4'h0, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 40'h0, 2'd1, 40'd9, 4'h0));

    // Counter 2: all lanes, preset near the top, wrap + sticky ovf + clear rules.
    vecs.push_back(mkv(64'h0, 4'h0, 4'h0, 1'b1, 2'd2, 32'hFFFF_FFFF, 1'b1, 2'd2, 40'hFF_FFFF_FFFE, 2'd2, 40'hFF_FFFF_FFFE, 4'h0));
    vecs.push_back(mkv(64'hB, 4'h0, 4'h0, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 40'h0, 2'd2, 40'hFF_FFFF_FFFE, 4'h0));
    vecs.push_back(mkv(64'h0, 4'h0, 4'h0, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 40'h0, 2'd2, 40'd3, 4'h4));
    vecs.push_back(mkv(64'h0, 4'h0, 4'h0, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 40'h0, 2'd2, 40'd3, 4'h4));
    vecs.push_back(mkv(64'h0, 4'h0, 4'h4, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 40'h0, 2'd2, 40'd3, 4'h0));
    vecs.push_back(mkv(64'h0, 4'h0, 4'h0, 1'b0, 2'd0, 32'h0, 1'b1, 2'd2, 40'hFF_FFFF_FFFF, 2'd2, 40'hFF_FFFF_FFFF, 4'h0));
    vecs.push_back(mkv(64'h1, 4'h0, 4'h0, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 40'h0, 2'd2, 40'hFF_FFFF_FFFF, 4'h0));
    vecs.push_back(mkv(64'h0, 4'h0, 4'h4, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 40'h0, 2'd2, 40'd0, 4'h4));
    vecs.push_back(mkv(64'h0, 4'h0, 4'h0, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 40'h0, 2'd2, 40'd0, 4'h4));
    vecs.push_back(mkv(64'h0, 4'h0, 4'h0, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 40'h0, 2'd0, 40'd34, 4'h4));
    vecs.push_back(mkv(64'h0, 4'h0, 4'h0, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 40'h0, 2'd1, 40'd11, 4'h4));

    for (int j = 0; j < vecs.size(); j++) apply(vecs[j], j);
    clear_inputs();

    // Software write while counter 0 counts 1/cycle: pending inc_q is dropped,
    // the write-cycle event lands on top of the written value.
    exp_q = '{40'd34, 40'd35, 40'd36, 40'd100, 40'd101, 40'd102, 40'd103, 40'd104, 40'd104};
    for (int k = 0; k < 9; k++) begin
      rd_idx    = 2'd0;
      evt_inc   = (k < 7) ? 64'h1 : 64'h0;
      ctr_we    = (k == 3);
      ctr_idx   = 2'd0;
      ctr_wdata = 40'd100;
      tick();
      check($sformatf("wr_seq%0d", k), 64'(rd_data), 64'(exp_q.pop_front()));
    end
    clear_inputs();

    // Counter 3 mask switch lane4 -> lane5; switch cycle uses the old mask.
    rd_idx = 2'd3;
    cfg_we = 1'b1; cfg_idx = 2'd3; cfg_wdata = 32'h10;
    tick();
    cfg_we = 1'b0;
    check("sel_lane4", 64'(rd_sel), 64'h10);
    evt_inc = 64'h500;
    repeat (3) tick();
    cfg_we = 1'b1; cfg_wdata = 32'h20;
    tick();
    cfg_we = 1'b0;
    repeat (3) tick();
    evt_inc = 64'h0;
    repeat (2) tick();
    check("switch_total", 64'(rd_data), 64'd7);
    check("sel_lane5", 64'(rd_sel), 64'h20);
    evt_inc = 64'h100;
    repeat (2) tick();
    evt_inc = 64'h0;
    repeat (2) tick();
    check("old_lane_ignored", 64'(rd_data), 64'd7);
    evt_inc = 64'h400; cfg_we = 1'b1; cfg_wdata = 32'h10;
    tick();
    cfg_we = 1'b0;
    tick();
    evt_inc = 64'h0;
    repeat (2) tick();
    check("switch_cycle_old_mask", 64'(rd_data), 64'd8);

    // Index 3 is out of range for the 3-counter instance.
    check("oor_rd_data", 64'(rd_data3), 64'h0);
    check("oor_rd_sel", 64'(rd_sel3), 64'h0);
    rd_idx = 2'd0; #1;
    check("oor_sel0_kept", 64'(rd_sel3), 64'h1);
    rd_idx = 2'd1; #1;
    check("oor_sel1_kept", 64'(rd_sel3), 64'h6);
    rd_idx = 2'd2; #1;
    check("oor_sel2_kept", 64'(rd_sel3), 64'hFFFF_FFFF);
    ctr_we = 1'b1; ctr_idx = 2'd3; ctr_wdata = 40'h123;
    tick();
    ctr_we = 1'b0;
    rd_idx = 2'd3; #1;
    check("ctr3_write", 64'(rd_data), 64'h123);
    check("oor_ctr_write", 64'(rd_data3), 64'h0);
    rd_idx = 2'd0; #1;
    check("oor_ctr0_kept", 64'(rd_data3), 64'd104);

`ifdef INSIGHT_HPM_SNAPSHOT_EN
    rd_idx = 2'd0; evt_inc = 64'h1;
    ctr_we = 1'b1; ctr_idx = 2'd0; ctr_wdata = 40'd1000;
    tick();
    ctr_we = 1'b0; snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    check("snap0_first", 64'(snap_data[39:0]), 64'd1001);
    check("snap_rd_match", 64'(rd_data), 64'd1001);
    check("snap1_first", 64'(snap_data[79:40]), 64'd11);
    check("snap3_first", 64'(snap_data[159:120]), 64'h123);
    tick();
    check("snap0_hold", 64'(snap_data[39:0]), 64'd1001);
    check("snap_counting", 64'(rd_data), 64'd1002);
    tick();
    snap_req = 1'b1; ctr_we = 1'b1; ctr_idx = 2'd1; ctr_wdata = 40'd77;
    tick();
    snap_req = 1'b0; ctr_we = 1'b0;
    check("snap0_second", 64'(snap_data[39:0]), 64'd1004);
    check("snap1_same_cycle_write", 64'(snap_data[79:40]), 64'd77);
    evt_inc = 64'h0;
    tick();
    check("snap0_hold2", 64'(snap_data[39:0]), 64'd1004);
    check("snap3_dut3", 64'(snap_data3[39:0]), 64'd1004);
`endif

    // Reset mid-count discards the pending increment and clears everything.
    rd_idx = 2'd0; evt_inc = 64'h1;
    tick();
    reset = 1'b1;
    tick();
    check("midrst_rd_data", 64'(rd_data), 64'h0);
    check("midrst_rd_sel", 64'(rd_sel), 64'h0);
    check("midrst_ovf", 64'(ovf), 64'h0);
    reset = 1'b0; evt_inc = 64'h0;
    tick();
    check("midrst_no_pending", 64'(rd_data), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
